// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (cpu/dbg) arbiter in front of the single data memory
// Optional DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_WAIT        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_cpu_req,
  input  logic                       in_cpu_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_cpu_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_cpu_wr_word,
  output logic                       out_cpu_gnt,
  output logic                       out_cpu_rd_valid,
  output logic [DMEM_WORD_WIDTH-1:0] out_cpu_rd_word,
  input  logic                       in_dbg_req,
  input  logic                       in_dbg_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dbg_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dbg_wr_word,
  output logic                       out_dbg_gnt,
  output logic                       out_dbg_rd_valid,
  output logic [DMEM_WORD_WIDTH-1:0] out_dbg_rd_word,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                       out_mem_write_en,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]                out_cpu_gnt_cnt,
  output logic [15:0]                out_dbg_gnt_cnt,
  output logic [15:0]                out_conflict_cnt,
`endif
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic                       cpu_gnt;
  logic                       dbg_gnt;
  logic                       dbg_wins;
  logic                       rd_accept;
  logic                       rd_owner;

  logic [3:0]                 wait_cnt_q, wait_cnt_d;
  logic [READ_LATENCY-1:0]    tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0]    tag_own_q, tag_own_d;
  logic                       cpu_rd_valid_q, cpu_rd_valid_d;
  logic                       dbg_rd_valid_q, dbg_rd_valid_d;
  logic [DMEM_WORD_WIDTH-1:0] cpu_rd_word_q, cpu_rd_word_d;
  logic [DMEM_WORD_WIDTH-1:0] dbg_rd_word_q, dbg_rd_word_d;

  // dbg overrides cpu only once it has been starved for MAX_WAIT cycles
  always_comb begin
    dbg_wins  = in_dbg_req && (!in_cpu_req || (wait_cnt_q == MAX_WAIT_C));
    dbg_gnt   = !reset && dbg_wins;
    cpu_gnt   = !reset && in_cpu_req && !dbg_wins;
    rd_accept = (cpu_gnt && !in_cpu_we) || (dbg_gnt && !in_dbg_we);
    rd_owner  = dbg_gnt;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!in_dbg_req || dbg_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    out_cpu_gnt      = cpu_gnt;
    out_dbg_gnt      = dbg_gnt;
    out_mem_rd_addr  = dbg_gnt ? in_dbg_addr : in_cpu_addr;
    out_mem_wr_addr  = dbg_gnt ? in_dbg_addr : in_cpu_addr;
    out_mem_wr_word  = dbg_gnt ? in_dbg_wr_word : in_cpu_wr_word;
    out_mem_write_en = (cpu_gnt && in_cpu_we) || (dbg_gnt && in_dbg_we);
  end

  // Tag shift register aligned with the memory read latency; owner 1 = dbg
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = rd_accept;
    tag_own_d[0] = rd_owner;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_comb begin
    cpu_rd_valid_d = tag_vld_q[READ_LATENCY-1] && !tag_own_q[READ_LATENCY-1];
    dbg_rd_valid_d = tag_vld_q[READ_LATENCY-1] && tag_own_q[READ_LATENCY-1];
    cpu_rd_word_d  = cpu_rd_valid_d ? in_mem_rd_word : cpu_rd_word_q;
    dbg_rd_word_d  = dbg_rd_valid_d ? in_mem_rd_word : dbg_rd_word_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q     <= 4'd0;
      tag_vld_q      <= '0;
      tag_own_q      <= '0;
      cpu_rd_valid_q <= 1'b0;
      dbg_rd_valid_q <= 1'b0;
      cpu_rd_word_q  <= '0;
      dbg_rd_word_q  <= '0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      tag_vld_q      <= tag_vld_d;
      tag_own_q      <= tag_own_d;
      cpu_rd_valid_q <= cpu_rd_valid_d;
      dbg_rd_valid_q <= dbg_rd_valid_d;
      cpu_rd_word_q  <= cpu_rd_word_d;
      dbg_rd_word_q  <= dbg_rd_word_d;
    end
  end

  assign out_cpu_rd_valid = cpu_rd_valid_q;
  assign out_dbg_rd_valid = dbg_rd_valid_q;
  assign out_cpu_rd_word  = cpu_rd_word_q;
  assign out_dbg_rd_word  = dbg_rd_word_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt_q, cpu_gnt_cnt_d;
  logic [15:0] dbg_gnt_cnt_q, dbg_gnt_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    cpu_gnt_cnt_d  = cpu_gnt_cnt_q;
    dbg_gnt_cnt_d  = dbg_gnt_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (cpu_gnt && (cpu_gnt_cnt_q != 16'hFFFF)) begin
      cpu_gnt_cnt_d = cpu_gnt_cnt_q + 16'd1;
    end
    if (dbg_gnt && (dbg_gnt_cnt_q != 16'hFFFF)) begin
      dbg_gnt_cnt_d = dbg_gnt_cnt_q + 16'd1;
    end
    if (in_cpu_req && in_dbg_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_gnt_cnt_q  <= 16'd0;
      dbg_gnt_cnt_q  <= 16'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      cpu_gnt_cnt_q  <= cpu_gnt_cnt_d;
      dbg_gnt_cnt_q  <= dbg_gnt_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign out_cpu_gnt_cnt  = cpu_gnt_cnt_q;
  assign out_dbg_gnt_cnt  = dbg_gnt_cnt_q;
  assign out_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter at read latencies 1 and 3
// Both instances share stimulus; DMEM_ARB_STATS_EN enables the counter scenario.
module tb_dmem_arbiter;

  localparam int MW = 4;

  typedef struct {
    int          due;
    bit          own;
    logic [15:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [11:0] cpu_addr = '0, dbg_addr = '0;
  logic [15:0] cpu_wr = '0, dbg_wr = '0;

  logic        g_cpu [2];
  logic        g_dbg [2];
  logic        v_cpu [2];
  logic        v_dbg [2];
  logic        we_o  [2];
  logic [15:0] w_cpu [2];
  logic [15:0] w_dbg [2];
  logic [15:0] ww    [2];
  logic [15:0] rdw   [2];
  logic [11:0] ra    [2];
  logic [11:0] wa    [2];
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cg [2];
  logic [15:0] dg [2];
  logic [15:0] cc [2];
`endif

  logic [15:0] mem [64];
  logic [15:0] p1;
  logic [15:0] p3 [3];
  logic        load_we = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [15:0] load_data = '0;

  logic [15:0] ref_mem [64];
  ent_t        sbq [2][$];
  logic [15:0] ew_cpu [2];
  logic [15:0] ew_dbg [2];
  int          mw = 0;
  int          cycle = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .READ_LATENCY(1), .MAX_WAIT(MW)) u_dut1 (
    .clock(clock), .reset(reset),
    .in_cpu_req(cpu_req), .in_cpu_we(cpu_we), .in_cpu_addr(cpu_addr), .in_cpu_wr_word(cpu_wr),
    .out_cpu_gnt(g_cpu[0]), .out_cpu_rd_valid(v_cpu[0]), .out_cpu_rd_word(w_cpu[0]),
    .in_dbg_req(dbg_req), .in_dbg_we(dbg_we), .in_dbg_addr(dbg_addr), .in_dbg_wr_word(dbg_wr),
    .out_dbg_gnt(g_dbg[0]), .out_dbg_rd_valid(v_dbg[0]), .out_dbg_rd_word(w_dbg[0]),
    .out_mem_rd_addr(ra[0]), .out_mem_wr_addr(wa[0]), .out_mem_wr_word(ww[0]),
    .out_mem_write_en(we_o[0]),
`ifdef DMEM_ARB_STATS_EN
    .out_cpu_gnt_cnt(cg[0]), .out_dbg_gnt_cnt(dg[0]), .out_conflict_cnt(cc[0]),
`endif
    .in_mem_rd_word(rdw[0])
  );

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .READ_LATENCY(3), .MAX_WAIT(MW)) u_dut3 (
    .clock(clock), .reset(reset),
    .in_cpu_req(cpu_req), .in_cpu_we(cpu_we), .in_cpu_addr(cpu_addr), .in_cpu_wr_word(cpu_wr),
    .out_cpu_gnt(g_cpu[1]), .out_cpu_rd_valid(v_cpu[1]), .out_cpu_rd_word(w_cpu[1]),
    .in_dbg_req(dbg_req), .in_dbg_we(dbg_we), .in_dbg_addr(dbg_addr), .in_dbg_wr_word(dbg_wr),
    .out_dbg_gnt(g_dbg[1]), .out_dbg_rd_valid(v_dbg[1]), .out_dbg_rd_word(w_dbg[1]),
    .out_mem_rd_addr(ra[1]), .out_mem_wr_addr(wa[1]), .out_mem_wr_word(ww[1]),
    .out_mem_write_en(we_o[1]),
`ifdef DMEM_ARB_STATS_EN
    .out_cpu_gnt_cnt(cg[1]), .out_dbg_gnt_cnt(dg[1]), .out_conflict_cnt(cc[1]),
`endif
    .in_mem_rd_word(rdw[1])
  );

  // Memory written through the latency-1 instance; each instance has its own read pipe
  always @(posedge clock) begin
    if (load_we) mem[load_addr] <= load_data;
    else if (we_o[0]) mem[wa[0][5:0]] <= ww[0];
    p1    <= mem[ra[0][5:0]];
    p3[0] <= mem[ra[1][5:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign rdw[0] = p1;
  assign rdw[1] = p3[2];

  task automatic cyc();
    logic eg_c, eg_d, exp_we, rd_g, exp_vc, exp_vd;
    logic [11:0] a;
    @(negedge clock);
    cycle++;
    eg_d = !reset && dbg_req && (!cpu_req || mw == MW);
    eg_c = !reset && cpu_req && !(dbg_req && (!cpu_req || mw == MW));
    exp_we = (eg_c && cpu_we) || (eg_d && dbg_we);
    rd_g = (eg_c && !cpu_we) || (eg_d && !dbg_we);
    a = eg_d ? dbg_addr : cpu_addr;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (g_cpu[k] !== eg_c || g_dbg[k] !== eg_d) begin
        fails++;
        $display("FAIL gnt dut%0d cyc%0d: got cpu=%b dbg=%b want cpu=%b dbg=%b", k, cycle, g_cpu[k], g_dbg[k], eg_c, eg_d);
      end
      tests++;
      if (we_o[k] !== exp_we) begin
        fails++;
        $display("FAIL write_en dut%0d cyc%0d: got %b want %b", k, cycle, we_o[k], exp_we);
      end
      if (exp_we) begin
        tests++;
        if (wa[k] !== a || ww[k] !== (eg_d ? dbg_wr : cpu_wr)) begin
          fails++;
          $display("FAIL wr_port dut%0d cyc%0d: got %h/%h want %h/%h", k, cycle, wa[k], ww[k], a, eg_d ? dbg_wr : cpu_wr);
        end
      end
      if (rd_g) begin
        tests++;
        if (ra[k] !== a) begin
          fails++;
          $display("FAIL rd_addr dut%0d cyc%0d: got %h want %h", k, cycle, ra[k], a);
        end
      end
      if (reset) begin
        sbq[k].delete();
        ew_cpu[k] = 16'h0;
        ew_dbg[k] = 16'h0;
      end
      exp_vc = sbq[k].size() > 0 && sbq[k][0].due == cycle && !sbq[k][0].own;
      exp_vd = sbq[k].size() > 0 && sbq[k][0].due == cycle && sbq[k][0].own;
      if (exp_vc) ew_cpu[k] = sbq[k][0].data;
      if (exp_vd) ew_dbg[k] = sbq[k][0].data;
      if (exp_vc || exp_vd) void'(sbq[k].pop_front());
      tests++;
      if (v_cpu[k] !== exp_vc || v_dbg[k] !== exp_vd) begin
        fails++;
        $display("FAIL rd_valid dut%0d cyc%0d: got cpu=%b dbg=%b want cpu=%b dbg=%b", k, cycle, v_cpu[k], v_dbg[k], exp_vc, exp_vd);
      end
      tests++;
      if (w_cpu[k] !== ew_cpu[k] || w_dbg[k] !== ew_dbg[k]) begin
        fails++;
        $display("FAIL rd_word dut%0d cyc%0d: got cpu=%h dbg=%h want cpu=%h dbg=%h", k, cycle, w_cpu[k], w_dbg[k], ew_cpu[k], ew_dbg[k]);
      end
      if (rd_g) sbq[k].push_back('{due: cycle + (k == 0 ? 2 : 4), own: eg_d, data: ref_mem[a[5:0]]});
    end
    if (exp_we) ref_mem[a[5:0]] = eg_d ? dbg_wr : cpu_wr;
    if (reset || !dbg_req || eg_d) mw = 0;
    else if (mw < MW) mw++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) begin
      @(posedge clock);
      #1;
      load_we = 1'b1;
      load_addr = 6'(i);
      load_data = (i == 16) ? 16'hBEEF : (16'h5A00 ^ 16'(i));
      ref_mem[i] = load_data;
    end
    @(posedge clock);
    #1;
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (v_cpu[k] !== 1'b0 || w_cpu[k] !== 16'h0 || w_dbg[k] !== 16'h0) begin
        fails++;
        $display("FAIL reset_outs dut%0d: got v=%b w=%h/%h want 0", k, v_cpu[k], w_cpu[k], w_dbg[k]);
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    #1;
    tests++;
    if (g_cpu[0] !== 1'b1) begin
      fails++;
      $display("FAIL cpu_read_gnt: got %b want 1", g_cpu[0]);
    end
    cyc();
    idle(5);
    tests++;
    if (w_cpu[0] !== 16'hBEEF || w_cpu[1] !== 16'hBEEF) begin
      fails++;
      $display("FAIL cpu_read_word: got %h/%h want beef", w_cpu[0], w_cpu[1]);
    end
  endtask

  task automatic test_dbg_write();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h020; dbg_wr = 16'h1234;
    #1;
    tests++;
    if (g_dbg[0] !== 1'b1 || we_o[0] !== 1'b1 || wa[0] !== 12'h020 || ww[0] !== 16'h1234) begin
      fails++;
      $display("FAIL dbg_write: got gnt=%b we=%b a=%h d=%h want 1 1 020 1234", g_dbg[0], we_o[0], wa[0], ww[0]);
    end
    cyc();
    dbg_we = 1'b0;
    cyc();
    idle(5);
    tests++;
    if (w_dbg[0] !== 16'h1234 || w_dbg[1] !== 16'h1234) begin
      fails++;
      $display("FAIL dbg_readback: got %h/%h want 1234", w_dbg[0], w_dbg[1]);
    end
  endtask

  task automatic test_conflict();
    cpu_req = 1'b1; cpu_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h030;
    for (int i = 0; i < 15; i++) begin
      cpu_addr = 12'(i);
      if (i % 5 == 0) dbg_addr = 12'h030 + 12'(i);
      #1;
      tests++;
      if (g_dbg[0] !== (i % 5 == 4) || g_cpu[0] !== (i % 5 != 4)) begin
        fails++;
        $display("FAIL conflict_pattern i=%0d: got cpu=%b dbg=%b want dbg=%b", i, g_cpu[0], g_dbg[0], i % 5 == 4);
      end
      cyc();
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h001;
    cyc();
    cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h002;
    cyc();
    idle(6);
    tests++;
    if (w_cpu[1] !== 16'h5A01 || w_dbg[1] !== 16'h5A02) begin
      fails++;
      $display("FAIL back_to_back_words: got %h/%h want 5a01/5a02", w_cpu[1], w_dbg[1]);
    end
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h003;
    cyc();
    cpu_req = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle(6);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (w_cpu[k] !== 16'h0 || w_dbg[k] !== 16'h0 || v_cpu[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_outs dut%0d: got v=%b w=%h/%h want 0", k, v_cpu[k], w_cpu[k], w_dbg[k]);
      end
    end
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 12'h004; dbg_addr = 12'h005;
    #1;
    tests++;
    if (g_cpu[1] !== 1'b1 || g_dbg[1] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_wait: got cpu=%b dbg=%b want 1 0", g_cpu[1], g_dbg[1]);
    end
    cyc();
    idle(6);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (cg[k] !== 16'd8 || dg[k] !== 16'd2 || cc[k] !== 16'd10) begin
        fails++;
        $display("FAIL stats dut%0d: got %0d/%0d/%0d want 8/2/10", k, cg[k], dg[k], cc[k]);
      end
    end
    idle(6);
  endtask
`endif

  initial begin
    preload();
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (sbq[k].size() != 0) begin
        fails++;
        $display("FAIL drain dut%0d: %0d reads never returned, want 0", k, sbq[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
